ntt_ctrl: RTL and testbench
===========================

Name: ntt_ctrl

Overview:
- In-place forward NTT engine for Dilithium polynomials (N=256, q=8380417) held in the 256x24 dual-port coefficient RAM.
- Sits directly in front of the RAM and is its only master during a transform. Drives both address ports and the shared write enable, consumes both registered read ports, and writes butterfly results back to the same addresses.
- Sequences 8 Cooley-Tukey layers of 128 butterflies each, and fetches twiddles from an external zeta ROM.

Parameters:
- Q, 8380417, modulus; coefficients canonical in [0,Q).
- DATA_W, 24, RAM word width; coefficient occupies bits [22:0], bit 23 written as 0.
- BF_LAT, 2, butterfly pipeline latency in cycles (min 1).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- busy_o  out  1  high while the transform is in progress.
- done_o  out  1  one-cycle pulse after the final write-back.
- addr1_o  out  8  RAM port-1 address, used for both read and write.
- addr2_o  out  8  RAM port-2 address, used for both read and write.
- wren_o  out  1  RAM write enable.
- data_wr1_o  out  DATA_W  write data to port 1 (a').
- data_wr2_o  out  DATA_W  write data to port 2 (b').
- data1_i  in  DATA_W  RAM port-1 read data; registered by the RAM, valid the cycle after the address is presented.
- data2_i  in  DATA_W  RAM port-2 read data, same timing as data1_i.
- zeta_idx_o  out  8  zeta ROM index.
- zeta_i  in  23  zeta value; ROM is registered, so it is valid the cycle after zeta_idx_o changes.

Behaviour:
- Clock is clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: every output 0; FSM in IDLE; layer, block and butterfly counters at 0.
- FSM states: IDLE -> READ -> CALC (BF_LAT cycles) -> WRITE -> READ ..., and after the last WRITE -> DONE -> IDLE.
- IDLE:
  - wren_o=0.
  - start_i=1 loads len=128, start=0, j=0, k=1, then goes to READ.
- Address and zeta generation (standard Dilithium order):
  - addr1_o=j, addr2_o=j+len, zeta_idx_o=k.
  - Addresses and zeta_idx_o are registered outputs, held constant from READ through WRITE.
- READ (1 cycle): wren_o=0; the RAM captures the read at the end of this cycle.
- CALC (BF_LAT cycles):
  - Samples data1_i, data2_i and zeta_i in the first CALC cycle.
  - Butterfly: t=(zeta*b) mod Q, a'=(a+t) mod Q, b'=(a-t+Q) mod Q.
  - Full 46-bit product; Barrett reduction; final conditional subtract/add, so results are always in [0,Q).
- WRITE (1 cycle):
  - wren_o=1; data_wr1_o=a' and data_wr2_o=b' are registered and stable for the whole cycle (the RAM writes on the falling edge).
  - Then advance: j++. When j==start+len: start=j+len, k++. When start>=256: len>>=1, start=0. When len would become 0, go to DONE.
- DONE: busy_o=0, done_o=1 for one cycle, then IDLE.
- wren_o is 0 in every state except WRITE. data_wr* hold their last value otherwise.
- busy_o is high in READ, CALC and WRITE.
- Timing: 1024 butterflies × (BF_LAT+2) cycles = 4096 busy cycles at the default BF_LAT.
- start_i during busy or DONE is ignored.
- Reset mid-transform: immediate IDLE with wren_o=0. RAM contents are partially transformed and undefined.
- Non-canonical inputs (≥Q): results undefined; not verified.

Optional Feature:
- Macro: NTT_CYC_CNT_EN.
- Defined: adds output cyc_cnt_o [15:0].
  - Cleared when start is accepted.
  - Increments every busy cycle.
  - Holds its value after done until the next start.
  - Reset value 0.
- Undefined: port absent; no counter logic.

Decomposition:
- Package ntt_pkg:
  - Q, N=256, LOG_N=8, DATA_W.
  - Barrett constants (shift, multiplier).
  - FSM state enum ntt_state_e {IDLE, READ, CALC, WRITE, DONE}.
- Sub-module ntt_butterfly:
  - Inputs a, b, zeta, valid_in.
  - Outputs a', b', valid_out, with a pipelined Barrett multiplier of latency BF_LAT.
  - Unit-tested standalone.

Test Plan:
- Impulse: RAM a[0]=1, rest 0, true zeta table; pulse start -> after done all 256 words = 1. Repeat with a[0]=5 -> all words = 5.
- Address/zeta trace:
  - Butterfly #0: (0,128,k=1).
  - Butterfly #128: (0,64,k=2).
  - Butterfly #192: (128,192,k=3).
  - Last butterfly: (254,255,k=255).
  - wren_o is high exactly one cycle per butterfly, 1024 total.
- Butterfly edge (unit): a=b=zeta=Q-1 -> t=1, a'=0, b'=Q-2. Also a=0, b=1, zeta=1 -> a'=1, b'=Q-1.
- Timing: busy_o high exactly 4096 cycles (BF_LAT=2); done_o a single pulse the cycle after the last WRITE; with NTT_CYC_CNT_EN, cyc_cnt_o=4096.
- start_i re-pulsed mid-transform -> no restart; counters and address trace unchanged.
- rst_ni low during layer 3 -> outputs 0 immediately, asynchronously; a fresh start then completes normally with a correct trace.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the Dilithium forward NTT controller and its butterfly.
package ntt_pkg;

    localparam int unsigned N      = 256;
    localparam int unsigned LOG_N  = 8;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned COEF_W = 23;
    localparam int unsigned PROD_W = 2 * COEF_W;

    localparam logic [COEF_W-1:0] Q = 23'd8380417;

    // m = floor(2^48 / Q); with products below 2^46 the quotient estimate is low by at most one
    localparam int unsigned BARRETT_SHIFT = 48;
    localparam int unsigned BARRETT_W     = 26;
    localparam logic [BARRETT_W-1:0] BARRETT_MULT =
        BARRETT_W'((64'd1 << BARRETT_SHIFT) / 64'(Q));

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        DONE
    } ntt_state_e;

endpackage

// File: rtl/ntt_butterfly.sv
// Cooley-Tukey butterfly a' = a + zeta*b, b' = a - zeta*b (mod Q) with Barrett reduction.
// Latency from valid_i to valid_o is BF_LAT cycles; outputs hold their last value when idle.
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int BF_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [COEF_W-1:0] a_i,
    input  logic [COEF_W-1:0] b_i,
    input  logic [COEF_W-1:0] zeta_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o
);

    localparam int OUT_STAGES = (BF_LAT > 1) ? BF_LAT - 1 : 1;
    localparam int MUL_W      = PROD_W + BARRETT_W;
    localparam int QHAT_W     = COEF_W + 1;
    localparam int REM_W      = COEF_W + 2;
    localparam int SUM_W      = COEF_W + 1;

    logic              prod_vld;
    logic [PROD_W-1:0] prod;
    logic [COEF_W-1:0] prod_a;

    generate
        if (BF_LAT > 1) begin : g_prod_reg
            logic              vld_q;
            logic [PROD_W-1:0] prod_q;
            logic [COEF_W-1:0] a_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q  <= 1'b0;
                    prod_q <= '0;
                    a_q    <= '0;
                end else begin
                    vld_q <= valid_i;
                    if (valid_i) begin
                        prod_q <= PROD_W'(b_i) * PROD_W'(zeta_i);
                        a_q    <= a_i;
                    end
                end
            end

            assign prod_vld = vld_q;
            assign prod     = prod_q;
            assign prod_a   = a_q;
        end else begin : g_prod_comb
            assign prod_vld = valid_i;
            assign prod     = PROD_W'(b_i) * PROD_W'(zeta_i);
            assign prod_a   = a_i;
        end
    endgenerate

    logic [QHAT_W-1:0] qhat;
    logic [REM_W-1:0]  rem;
    logic [COEF_W-1:0] t;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  diff;
    logic [COEF_W-1:0] a_new;
    logic [COEF_W-1:0] b_new;

    always_comb begin
        qhat  = QHAT_W'((MUL_W'(prod) * MUL_W'(BARRETT_MULT)) >> BARRETT_SHIFT);
        rem   = REM_W'(prod - PROD_W'(qhat) * PROD_W'(Q));
        t     = (rem >= REM_W'(Q)) ? COEF_W'(rem - REM_W'(Q)) : rem[COEF_W-1:0];
        sum   = SUM_W'(prod_a) + SUM_W'(t);
        diff  = SUM_W'(prod_a) + SUM_W'(Q) - SUM_W'(t);
        a_new = (sum >= SUM_W'(Q))  ? COEF_W'(sum - SUM_W'(Q))  : sum[COEF_W-1:0];
        b_new = (diff >= SUM_W'(Q)) ? COEF_W'(diff - SUM_W'(Q)) : diff[COEF_W-1:0];
    end

    logic [OUT_STAGES-1:0] v_pipe;
    logic [COEF_W-1:0]     a_pipe [OUT_STAGES];
    logic [COEF_W-1:0]     b_pipe [OUT_STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_pipe <= '0;
            for (int i = 0; i < OUT_STAGES; i++) begin
                a_pipe[i] <= '0;
                b_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= prod_vld;
            if (prod_vld) begin
                a_pipe[0] <= a_new;
                b_pipe[0] <= b_new;
            end
            for (int i = 1; i < OUT_STAGES; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                if (v_pipe[i-1]) begin
                    a_pipe[i] <= a_pipe[i-1];
                    b_pipe[i] <= b_pipe[i-1];
                end
            end
        end
    end

    assign valid_o = v_pipe[OUT_STAGES-1];
    assign a_o     = {1'b0, a_pipe[OUT_STAGES-1]};
    assign b_o     = {1'b0, b_pipe[OUT_STAGES-1]};

endmodule

// File: rtl/ntt_ctrl.sv
// In-place forward NTT sequencer for Dilithium: masters the dual-port coefficient RAM and zeta ROM.
// Define NTT_CYC_CNT_EN to add the cyc_cnt_o busy-cycle counter.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | addresses presented; RAM and ROM capture at end of cycle
// CALC  | butterfly pipeline running for BF_LAT cycles
// WRITE | a'/b' written back to the same addresses, counters advance
// DONE  | one-cycle completion pulse
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int BF_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LOG_N-1:0]  addr1_o,
    output logic [LOG_N-1:0]  addr2_o,
    output logic              wren_o,
    output logic [DATA_W-1:0] data_wr1_o,
    output logic [DATA_W-1:0] data_wr2_o,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic [LOG_N-1:0]  zeta_idx_o,
    input  logic [COEF_W-1:0] zeta_i
`ifdef NTT_CYC_CNT_EN
    ,
    output logic [15:0]       cyc_cnt_o
`endif
);

    localparam int CNT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    ntt_state_e       state_q, state_d;
    logic [CNT_W-1:0] calc_cnt_q;

    logic [LOG_N-1:0] len_q, k_q;
    logic [LOG_N:0]   start_q, j_q;
    logic [LOG_N-1:0] addr1_q, addr2_q, zeta_idx_q;

    logic [LOG_N-1:0] nxt_len, nxt_k;
    logic [LOG_N:0]   nxt_start, nxt_j, j_inc;
    logic             last_bf;
    logic             start_accept;
    logic             bf_valid_in, bf_valid_out;
    logic             unused_msb;

    assign start_accept = (state_q == IDLE) && start_i;
    assign unused_msb   = data1_i[DATA_W-1] ^ data2_i[DATA_W-1];

    // Loop-nest advance: next butterfly in block, next block, next layer
    always_comb begin
        j_inc     = j_q + 1'b1;
        nxt_j     = j_inc;
        nxt_start = start_q;
        nxt_len   = len_q;
        nxt_k     = k_q;
        last_bf   = 1'b0;
        if (j_inc == start_q + {1'b0, len_q}) begin
            nxt_k     = k_q + 1'b1;
            nxt_start = j_inc + {1'b0, len_q};
            nxt_j     = nxt_start;
            if (nxt_start >= (LOG_N+1)'(N)) begin
                nxt_len   = len_q >> 1;
                nxt_start = '0;
                nxt_j     = '0;
                last_bf   = (len_q == LOG_N'(1));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q      <= '0;
            start_q    <= '0;
            j_q        <= '0;
            k_q        <= '0;
            addr1_q    <= '0;
            addr2_q    <= '0;
            zeta_idx_q <= '0;
        end else if (start_accept) begin
            len_q      <= LOG_N'(N / 2);
            start_q    <= '0;
            j_q        <= '0;
            k_q        <= LOG_N'(1);
            addr1_q    <= '0;
            addr2_q    <= LOG_N'(N / 2);
            zeta_idx_q <= LOG_N'(1);
        end else if (state_q == WRITE && !last_bf) begin
            len_q      <= nxt_len;
            start_q    <= nxt_start;
            j_q        <= nxt_j;
            k_q        <= nxt_k;
            addr1_q    <= nxt_j[LOG_N-1:0];
            addr2_q    <= nxt_j[LOG_N-1:0] + nxt_len;
            zeta_idx_q <= nxt_k;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            calc_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            calc_cnt_q <= (state_q == CALC) ? calc_cnt_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = READ;
            READ:    state_d = CALC;
            CALC:    if (calc_cnt_q == CNT_W'(BF_LAT - 1)) state_d = WRITE;
            WRITE:   state_d = last_bf ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM read data is valid in the first CALC cycle, so the butterfly takes it then
    assign bf_valid_in = (state_q == CALC) && (calc_cnt_q == '0);

    ntt_butterfly #(
        .BF_LAT (BF_LAT)
    ) u_butterfly (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (bf_valid_in),
        .a_i     (data1_i[COEF_W-1:0]),
        .b_i     (data2_i[COEF_W-1:0]),
        .zeta_i  (zeta_i),
        .valid_o (bf_valid_out),
        .a_o     (data_wr1_o),
        .b_o     (data_wr2_o)
    );

    assign busy_o     = (state_q == READ) || (state_q == CALC) || (state_q == WRITE);
    assign done_o     = (state_q == DONE);
    assign wren_o     = (state_q == WRITE) && bf_valid_out;
    assign addr1_o    = addr1_q;
    assign addr2_o    = addr2_q;
    assign zeta_idx_o = zeta_idx_q;

`ifdef NTT_CYC_CNT_EN
    logic [15:0] cyc_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_cnt_q <= '0;
        end else if (start_accept) begin
            cyc_cnt_q <= '0;
        end else if (busy_o) begin
            cyc_cnt_q <= cyc_cnt_q + 16'd1;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl with a behavioural dual-port RAM and registered zeta ROM.
module tb_ntt_ctrl;

    localparam longint QL = 64'd8380417;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, wren;
    logic [7:0]  addr1, addr2, zidx;
    logic [23:0] wr1, wr2, rd1, rd2;
    logic [22:0] zrd;
`ifdef NTT_CYC_CNT_EN
    logic [15:0] cyc_cnt;
`endif

    logic        bf_v;
    logic [22:0] bf_a, bf_b, bf_z;
    logic        bf_vo;
    logic [23:0] bf_ao, bf_bo;

    logic [23:0] mem     [256];
    logic [23:0] img     [256];
    logic [23:0] exp_img [256];
    logic [22:0] zeta_tab[256];
    logic        ram_load;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ntt_ctrl u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .addr1_o    (addr1),
        .addr2_o    (addr2),
        .wren_o     (wren),
        .data_wr1_o (wr1),
        .data_wr2_o (wr2),
        .data1_i    (rd1),
        .data2_i    (rd2),
        .zeta_idx_o (zidx),
        .zeta_i     (zrd)
`ifdef NTT_CYC_CNT_EN
        ,
        .cyc_cnt_o  (cyc_cnt)
`endif
    );

    ntt_butterfly u_bf (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (bf_v),
        .a_i     (bf_a),
        .b_i     (bf_b),
        .zeta_i  (bf_z),
        .valid_o (bf_vo),
        .a_o     (bf_ao),
        .b_o     (bf_bo)
    );

    always @(posedge clk) begin
        rd1 <= mem[addr1];
        rd2 <= mem[addr2];
        zrd <= zeta_tab[zidx];
    end

    always @(negedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (wren) begin
            mem[addr1] <= wr1;
            mem[addr2] <= wr2;
        end
    end

    // Per-run trace monitor, cleared when an accepted start is seen
    int          wr_cnt = 0, busy_cnt = 0, done_cnt = 0, dbl_wr = 0;
    logic        done_ok = 1'b0, prev_wren = 1'b0;
    logic [23:0] tr0, tr128, tr192, tr1023;

    always @(negedge clk) begin
        if (rst_n && start && !busy && !done) begin
            wr_cnt   <= 0;
            busy_cnt <= 0;
            done_cnt <= 0;
            dbl_wr   <= 0;
            done_ok  <= 1'b0;
        end else if (rst_n) begin
            if (busy) busy_cnt <= busy_cnt + 1;
            if (wren) begin
                if (wr_cnt == 0)    tr0    <= {addr1, addr2, zidx};
                if (wr_cnt == 128)  tr128  <= {addr1, addr2, zidx};
                if (wr_cnt == 192)  tr192  <= {addr1, addr2, zidx};
                if (wr_cnt == 1023) tr1023 <= {addr1, addr2, zidx};
                if (prev_wren) dbl_wr <= dbl_wr + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (prev_wren && wr_cnt == 1024) done_ok <= 1'b1;
            end
        end
        prev_wren <= wren;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic load_ram();
        @(posedge clk); #1 ram_load = 1'b1;
        @(posedge clk); #1 ram_load = 1'b0;
    endtask

    task automatic run_ntt(input string tag, input int repulse_at);
        int cyc;
        bit got;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            if (repulse_at != 0 && cyc == repulse_at) begin
                #1 start = 1'b1;
                @(negedge clk);
                cyc++;
                #1 start = 1'b0;
            end
        end
        check_val({tag, "_done_seen"}, 64'(got), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_trace(input string tag);
        check_val({tag, "_bf0"},    64'(tr0),    64'({8'd0,   8'd128, 8'd1}));
        check_val({tag, "_bf128"},  64'(tr128),  64'({8'd0,   8'd64,  8'd2}));
        check_val({tag, "_bf192"},  64'(tr192),  64'({8'd128, 8'd192, 8'd3}));
        check_val({tag, "_bf1023"}, 64'(tr1023), 64'({8'd254, 8'd255, 8'd255}));
        check_val({tag, "_wren_cnt"}, 64'(wr_cnt), 64'd1024);
        check_val({tag, "_wren_b2b"}, 64'(dbl_wr), 64'd0);
        check_val({tag, "_busy_cyc"}, 64'(busy_cnt), 64'd4096);
        check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check_val({tag, "_done_pos"}, 64'(done_ok), 64'd1);
`ifdef NTT_CYC_CNT_EN
        check_val({tag, "_cyc_cnt"}, 64'(cyc_cnt), 64'd4096);
`endif
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 256; i++)
            check_val($sformatf("%s_w%0d", tag, i), 64'(mem[i]), 64'(exp_img[i]));
    endtask

    task automatic set_impulse(input logic [23:0] v);
        for (int i = 0; i < 256; i++) begin
            img[i]     = 24'd0;
            exp_img[i] = v;
        end
        img[0] = v;
    endtask

    task automatic build_model();
        longint p[256];
        longint t, a0;
        int     k;
        for (int i = 0; i < 256; i++) p[i] = longint'(img[i]);
        k = 0;
        for (int len = 128; len > 0; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                k++;
                for (int j = st; j < st + len; j++) begin
                    t          = (longint'(zeta_tab[k]) * p[j+len]) % QL;
                    a0         = p[j];
                    p[j]       = (a0 + t) % QL;
                    p[j+len]   = (a0 - t + QL) % QL;
                end
            end
        end
        for (int i = 0; i < 256; i++) exp_img[i] = 24'(p[i]);
    endtask

    task automatic bf_case(input string tag, input logic [22:0] a, input logic [22:0] b,
                           input logic [22:0] z, input logic [22:0] ea, input logic [22:0] eb);
        int n;
        @(posedge clk); #1 bf_a = a; bf_b = b; bf_z = z; bf_v = 1'b1;
        @(posedge clk); #1 bf_v = 1'b0;
        n = 1;
        while (!bf_vo && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_vld"}, 64'(bf_vo), 64'd1);
        check_val({tag, "_lat"}, 64'(n), 64'd2);
        check_val({tag, "_a"}, 64'(bf_ao), 64'(ea));
        check_val({tag, "_b"}, 64'(bf_bo), 64'(eb));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     br, cyc;
        longint z;
        rst_n    = 1'b0;
        start    = 1'b0;
        ram_load = 1'b0;
        bf_v     = 1'b0;
        bf_a     = '0;
        bf_b     = '0;
        bf_z     = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            img[i] = '0;
        end
        // zeta[k] = 1753^bitrev8(k) mod Q
        for (int k = 0; k < 256; k++) begin
            br = 0;
            for (int b = 0; b < 8; b++) if (k[b]) br = br | (1 << (7 - b));
            z = 1;
            for (int e = 0; e < br; e++) z = (z * 1753) % QL;
            zeta_tab[k] = 23'(z);
        end

        #1;
        check_val("rst_ctrl", 64'({busy, done, wren, addr1, addr2, zidx}), 64'd0);
        check_val("rst_data", 64'({wr1, wr2}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        bf_case("bf_max",  23'(QL - 1), 23'(QL - 1), 23'(QL - 1), 23'd0, 23'(QL - 2));
        bf_case("bf_one",  23'd0, 23'd1, 23'd1, 23'd1, 23'(QL - 1));
        bf_case("bf_bz",   23'd5, 23'd0, 23'd77, 23'd5, 23'd5);
        bf_case("bf_small", 23'd100, 23'd3, 23'd2, 23'd106, 23'd94);
        bf_case("bf_wrapn", 23'd1, 23'(QL - 1), 23'd2, 23'(QL - 1), 23'd3);
        bf_case("bf_red",  23'd0, 23'd4194304, 23'd2, 23'd8191, 23'd8372226);

        set_impulse(24'd1);
        load_ram();
        run_ntt("imp1", 0);
        check_trace("imp1");
        check_mem("imp1");

        set_impulse(24'd5);
        load_ram();
        run_ntt("imp5", 0);
        check_mem("imp5");

        for (int i = 0; i < 256; i++) img[i] = 24'((longint'(i) * 7654321 + 11) % QL);
        img[3] = 24'(QL - 1);
        build_model();
        load_ram();
        run_ntt("poly", 1500);
        check_trace("poly");
        check_mem("poly");

        set_impulse(24'd1);
        load_ram();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (wr_cnt < 300 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("rst_reach_l3", 64'(wr_cnt >= 300), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_ctrl", 64'({busy, done, wren, addr1, addr2, zidx}), 64'd0);
        check_val("midrst_data", 64'({wr1, wr2}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("post_rst_idle", 64'({busy, done, wren}), 64'd0);
        load_ram();
        run_ntt("rerun", 0);
        check_trace("rerun");
        check_mem("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
